// File: rtl/icache_pkg.sv
// Shared definitions for the instruction-cache RAM array.
//   - ic_state_e : tag-maintenance sequencer states
//   - DEF_*      : default cache geometry
//   - log2_ceil  : index/address width helper
//   - valid_bit_pos : position of the valid bit inside a tag entry
package icache_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_INV1  = 2'd2,
    ST_FLUSH = 2'd3
  } ic_state_e;

  localparam int DEF_WAYS   = 2;
  localparam int DEF_SETS   = 256;
  localparam int DEF_TAG_W  = 21;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_BEATS  = 4;

  // Returns 0 for n <= 1, so BEATS = 1 yields a data address equal to the set index.
  function automatic int log2_ceil(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // A tag entry is {valid, tag}: the valid bit sits directly above the tag.
  function automatic int valid_bit_pos(input int tag_w);
    return tag_w;
  endfunction

endpackage

// File: rtl/ic_sram_1p.sv
// Single-port synchronous RAM, 2**AW x WIDTH.
//   clk, resetn : clock, synchronous active-low reset (output register only)
//   en, wr      : access enable, write (1) / read (0)
//   keep_rdata  : a write leaves rdata untouched (maintenance writes)
//   addr, wdata : address, write data
//   rdata       : registered read data, 1-cycle latency, write-first,
//                 held when en = 0
// This is the block replaced by vendor SRAM macros.
module ic_sram_1p #(
  parameter int AW    = 8,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic             wr,
  input  logic             keep_rdata,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset; real SRAM macros cannot clear their contents,
  // so anything that must be defined after reset is cleared by a sweep instead.
  always_ff @(posedge clk) begin
    if (en && wr) mem[addr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rdata <= '0;
    end else if (en) begin
      if (!wr)             rdata <= mem[addr];
      else if (!keep_rdata) rdata <= wdata;
    end
  end

endmodule

// File: rtl/icache_ram_array.sv
// Instruction-cache RAM array: WAYS tag RAMs ({valid, tag} entries) and WAYS
// data RAMs, one synchronous port each, plus a tag-maintenance sequencer that
// clears every entry after reset (INIT), on a whole-cache invalidate (FLUSH)
// and for one set on a single-set invalidate (INV1).
//   tag_en/tag_wr/tag_addr/tag_wdata -> tag_rdata : host tag port, slice per way
//   data_en/data_wr/data_addr/data_wdata -> data_rdata : host data port, per way
//   inv_req/inv_all/inv_addr : invalidate request, taken only when tag_ready
//   tag_ready : tag port and invalidate input are live (sequencer idle)
module icache_ram_array
  import icache_pkg::*;
#(
  parameter int WAYS   = DEF_WAYS,
  parameter int SETS   = DEF_SETS,
  parameter int TAG_W  = DEF_TAG_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int BEATS  = DEF_BEATS,
  localparam int IDX_W     = log2_ceil(SETS),
  localparam int DA_W      = IDX_W + log2_ceil(BEATS),
  localparam int VALID_BIT = valid_bit_pos(TAG_W),
  localparam int ENT_W     = VALID_BIT + 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [WAYS-1:0]        tag_en,
  input  logic                   tag_wr,
  input  logic [IDX_W-1:0]       tag_addr,
  input  logic [WAYS*ENT_W-1:0]  tag_wdata,
  output logic [WAYS*ENT_W-1:0]  tag_rdata,
  input  logic [WAYS-1:0]        data_en,
  input  logic                   data_wr,
  input  logic [WAYS*DA_W-1:0]   data_addr,
  input  logic [WAYS*DATA_W-1:0] data_wdata,
  output logic [WAYS*DATA_W-1:0] data_rdata,
  input  logic                   inv_req,
  input  logic                   inv_all,
  input  logic [IDX_W-1:0]       inv_addr,
  output logic                   tag_ready
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SETS - 1);

  ic_state_e        state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] inv_set_q, inv_set_d;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      inv_set_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      inv_set_q <= inv_set_d;
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    state_d   = state_q;
    cnt_d     = cnt_q;
    inv_set_d = inv_set_q;
    unique case (state_q)
      ST_INIT, ST_FLUSH: begin
        // The counter is returned to 0 by the exit transition, never by overflow.
        if (cnt_q == LAST_IDX) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      ST_IDLE: begin
        if (inv_req) begin
          if (inv_all) begin
            state_d = ST_FLUSH;
            cnt_d   = '0;
          end else begin
            state_d   = ST_INV1;
            inv_set_d = inv_addr;
          end
        end
      end
      ST_INV1: state_d = ST_IDLE;
      default: state_d = ST_INIT;
    endcase
  end

  logic                  maint;
  logic [WAYS-1:0]       tag_ram_en;
  logic                  tag_ram_wr;
  logic [IDX_W-1:0]      tag_ram_addr;
  logic [WAYS*ENT_W-1:0] tag_ram_wdata;

  // The sequencer owns the tag RAMs whenever it is not idle. An invalidate
  // accepted in IDLE wins over a host access in the same cycle.
  always_comb begin
    tag_ready     = (state_q == ST_IDLE);
    maint         = !tag_ready;
    tag_ram_en    = (tag_ready && !inv_req) ? tag_en : '0;
    tag_ram_wr    = tag_wr;
    tag_ram_addr  = tag_addr;
    tag_ram_wdata = tag_wdata;
    if (maint) begin
      tag_ram_en    = '1;
      tag_ram_wr    = 1'b1;
      tag_ram_addr  = (state_q == ST_INV1) ? inv_set_q : cnt_q;
      tag_ram_wdata = '0;
    end
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    // Sweep writes must not disturb what the host last read.
    ic_sram_1p #(.AW(IDX_W), .WIDTH(ENT_W)) u_tag (
      .clk        (clk),
      .resetn     (resetn),
      .en         (tag_ram_en[w]),
      .wr         (tag_ram_wr),
      .keep_rdata (maint),
      .addr       (tag_ram_addr),
      .wdata      (tag_ram_wdata[w*ENT_W +: ENT_W]),
      .rdata      (tag_rdata[w*ENT_W +: ENT_W])
    );

    ic_sram_1p #(.AW(DA_W), .WIDTH(DATA_W)) u_data (
      .clk        (clk),
      .resetn     (resetn),
      .en         (data_en[w]),
      .wr         (data_wr),
      .keep_rdata (1'b0),
      .addr       (data_addr[w*DA_W +: DA_W]),
      .wdata      (data_wdata[w*DATA_W +: DATA_W]),
      .rdata      (data_rdata[w*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_icache_ram_array.sv
// Directed bench for icache_ram_array at WAYS=2, SETS=256, TAG_W=21,
// DATA_W=64, BEATS=4 (IDX_W=8, DA_W=10, entry width 22).
module tb_icache_ram_array;

  localparam int WAYS = 2, SETS = 256, TAG_W = 21, DATA_W = 64, BEATS = 4;
  localparam int IDX_W = 8, DA_W = 10, ENT_W = TAG_W + 1;

  logic                   clk = 1'b0;
  logic                   resetn;
  logic [WAYS-1:0]        tag_en;
  logic                   tag_wr;
  logic [IDX_W-1:0]       tag_addr;
  logic [WAYS*ENT_W-1:0]  tag_wdata;
  logic [WAYS*ENT_W-1:0]  tag_rdata;
  logic [WAYS-1:0]        data_en;
  logic                   data_wr;
  logic [WAYS*DA_W-1:0]   data_addr;
  logic [WAYS*DATA_W-1:0] data_wdata;
  logic [WAYS*DATA_W-1:0] data_rdata;
  logic                   inv_req;
  logic                   inv_all;
  logic [IDX_W-1:0]       inv_addr;
  logic                   tag_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  icache_ram_array #(
    .WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W), .DATA_W(DATA_W), .BEATS(BEATS)
  ) dut (
    .clk(clk), .resetn(resetn),
    .tag_en(tag_en), .tag_wr(tag_wr), .tag_addr(tag_addr),
    .tag_wdata(tag_wdata), .tag_rdata(tag_rdata),
    .data_en(data_en), .data_wr(data_wr), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata),
    .inv_req(inv_req), .inv_all(inv_all), .inv_addr(inv_addr),
    .tag_ready(tag_ready)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts rising edges until tag_ready is seen high, bounded.
  task automatic wait_ready(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!tag_ready && n < 1000);
  endtask

  function automatic logic [63:0] pat(input int a);
    return 64'h0123_4567_0000_0000 ^ (64'(a) * 64'h0000_0000_9E37_79B9);
  endfunction

  function automatic logic [ENT_W-1:0] way_tag(input int w);
    return tag_rdata[w*ENT_W +: ENT_W];
  endfunction

  localparam logic [ENT_W-1:0] E0 = 22'h2ABCDE;  // tag 0x0ABCDE, valid
  localparam logic [ENT_W-1:0] E1 = 22'h212345;  // tag 0x012345, valid

  initial begin
    int n;
    int low;
    bit seen_high;

    resetn = 1'b0; tag_en = '0; tag_wr = 1'b0; tag_addr = '0; tag_wdata = '0;
    data_en = '0; data_wr = 1'b0; data_addr = '0; data_wdata = '0;
    inv_req = 1'b0; inv_all = 1'b0; inv_addr = '0;
    tick(); tick();

    // Reset values
    check("rst_tag_rdata", 64'(tag_rdata), 64'd0);
    check("rst_data_rdata", data_rdata[63:0] | data_rdata[127:64], 64'd0);
    check("rst_tag_ready", 64'(tag_ready), 64'd0);

    // Post-reset clear: ready exactly 256 edges after release
    resetn = 1'b1;
    wait_ready(n);
    check("init_len", 64'(n), 64'd256);

    for (int s = 0; s < SETS; s++) begin
      tag_en = 2'b11; tag_wr = 1'b0; tag_addr = IDX_W'(s);
      tick();
      check("init_valid", {62'd0, tag_rdata[ENT_W+TAG_W], tag_rdata[TAG_W]}, 64'd0);
    end
    tag_en = '0;

    // Write/read with way isolation
    tag_en = 2'b01; tag_wr = 1'b1; tag_addr = 8'd5; tag_wdata = {E1, E0};
    tick();
    check("wr_way0_first", 64'(way_tag(0)), 64'(E0));
    check("wr_way0_iso", 64'(way_tag(1)), 64'd0);
    tag_en = 2'b10;
    tick();
    check("wr_way1_first", 64'(way_tag(1)), 64'(E1));
    check("wr_way1_iso", 64'(way_tag(0)), 64'(E0));
    tag_en = '0; tag_wdata = '0;
    tick();
    tag_en = 2'b11; tag_wr = 1'b0; tag_addr = 8'd6;
    tick();
    check("rd_set6_w0", 64'(way_tag(0)), 64'd0);
    tag_addr = 8'd5;
    tick();
    check("rd_set5", 64'(tag_rdata), 64'({E1, E0}));
    tag_en = 2'b01; tag_addr = 8'd6;
    tick();
    check("rd_iso_w0", 64'(way_tag(0)), 64'd0);
    check("rd_iso_w1_hold", 64'(way_tag(1)), 64'(E1));

    // Single-set invalidate
    tag_en = 2'b11; tag_wr = 1'b1; tag_addr = 8'd3; tag_wdata = {22'h200133, 22'h200033};
    tick();
    tag_addr = 8'd4; tag_wdata = {22'h200144, 22'h200044};
    tick();
    tag_en = '0; tag_wr = 1'b0;
    inv_req = 1'b1; inv_all = 1'b0; inv_addr = 8'd3;
    tick();
    inv_req = 1'b0;
    check("inv1_ready_low", 64'(tag_ready), 64'd0);
    tick();
    check("inv1_ready_back", 64'(tag_ready), 64'd1);
    tag_en = 2'b11; tag_addr = 8'd3;
    tick();
    check("inv1_set3", 64'(tag_rdata), 64'd0);
    tag_addr = 8'd4;
    tick();
    check("inv1_set4", 64'(tag_rdata), 64'({22'h200144, 22'h200044}));
    tag_en = '0;

    // Fill data way1 0..1023 (write-first visible each cycle)
    data_en = 2'b10; data_wr = 1'b1;
    for (int a = 0; a < 1024; a++) begin
      data_addr = {DA_W'(a), DA_W'(0)};
      data_wdata = {pat(a), 64'd0};
      tick();
      check("data_wr_first", data_rdata[127:64], pat(a));
    end

    // Flush while streaming data reads on way1
    data_wr = 1'b0; data_addr = {DA_W'(0), DA_W'(0)};
    inv_req = 1'b1; inv_all = 1'b1;
    tick();
    inv_req = 1'b0; inv_all = 1'b0;
    low = 0; seen_high = 1'b0;
    for (int i = 1; i <= 1024; i++) begin
      check("flush_data_rd", data_rdata[127:64], pat(i - 1));
      if (!tag_ready && !seen_high) low++;
      else seen_high = 1'b1;
      if (i < 1024) begin
        data_addr = {DA_W'(i), DA_W'(0)};
        tick();
      end
    end
    data_en = '0;
    check("flush_len", 64'(low), 64'd256);
    for (int s = 0; s < SETS; s++) begin
      tag_en = 2'b11; tag_wr = 1'b0; tag_addr = IDX_W'(s);
      tick();
      check("flush_valid", {62'd0, tag_rdata[ENT_W+TAG_W], tag_rdata[TAG_W]}, 64'd0);
    end
    tag_en = '0;

    // Collision: invalidate set 0 and a tag write to set 7 in the same cycle
    tag_en = 2'b01; tag_wr = 1'b1; tag_addr = 8'd7; tag_wdata = {22'd0, E0};
    inv_req = 1'b1; inv_all = 1'b0; inv_addr = 8'd0;
    tick();
    tag_en = '0; tag_wr = 1'b0;
    check("coll_rdata_hold", 64'(way_tag(0)), 64'd0);
    check("coll_inv1", 64'(tag_ready), 64'd0);
    // inv_req while not ready is ignored (would otherwise start a flush)
    inv_all = 1'b1;
    tick();
    inv_req = 1'b0; inv_all = 1'b0;
    check("inv_ignored", 64'(tag_ready), 64'd1);
    tag_en = 2'b01; tag_addr = 8'd7;
    tick();
    check("coll_wr_dropped", 64'(way_tag(0)), 64'd0);
    tag_en = '0;

    // Reset at flush cycle 100 restarts the full INIT sweep
    inv_req = 1'b1; inv_all = 1'b1;
    tick();
    inv_req = 1'b0; inv_all = 1'b0;
    repeat (99) tick();
    check("midflush_busy", 64'(tag_ready), 64'd0);
    resetn = 1'b0;
    tick();
    check("midflush_rst_ready", 64'(tag_ready), 64'd0);
    check("midflush_rst_rdata", 64'(tag_rdata), 64'd0);
    resetn = 1'b1;
    wait_ready(n);
    check("reinit_len", 64'(n), 64'd256);

    // Data read-during-write and hold while disabled
    data_en = 2'b01; data_wr = 1'b1;
    data_addr = {DA_W'(0), DA_W'(9)};
    data_wdata = {64'd0, 64'hDEAD_BEEF_CAFE_F00D};
    tick();
    check("rdw_data", data_rdata[63:0], 64'hDEAD_BEEF_CAFE_F00D);
    data_en = '0; data_addr = {DA_W'(0), DA_W'(10)}; data_wdata = '1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("data_hold", data_rdata[63:0], 64'hDEAD_BEEF_CAFE_F00D);
    end
    data_en = 2'b01; data_wr = 1'b0; data_addr = {DA_W'(0), DA_W'(9)};
    tick();
    check("data_readback", data_rdata[63:0], 64'hDEAD_BEEF_CAFE_F00D);
    data_en = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
